// File: rtl/lfsr_axis_src.sv
// AXI-Stream burst source emitting zero-extended Galois LFSR samples.
// Define LFSR_THROTTLE_EN to insert pseudo-random valid gaps between beats.
module lfsr_axis_src #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter int unsigned                LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0]      SEED       = 16'hACE1,
  parameter logic [LFSR_WIDTH-1:0]      TAPS       = 16'hB400
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [15:0]           burst_len,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sent_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q;
  logic [15:0]             len_q;
  logic [15:0]             cnt_q;
  logic                    tvalid;
  logic                    last_beat;
  logic                    hs;

  assign last_beat = (cnt_q == len_q - 16'd1);
  assign hs        = tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (burst_len != 16'd0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (hs && last_beat) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr_q <= SEED;
      len_q  <= 16'd0;
      cnt_q  <= 16'd0;
    end else begin
      if (state_q == StIdle) begin
        // Seed load lands on the same edge as start, so the first beat carries it.
        if (seed_load) begin
          lfsr_q <= (seed_value == '0) ? SEED : seed_value;
        end
        if (start) begin
          len_q <= burst_len;
          cnt_q <= 16'd0;
        end
      end else if (state_q == StRun && hs) begin
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        cnt_q  <= cnt_q + 16'd1;
      end
    end
  end

`ifdef LFSR_THROTTLE_EN
  logic [7:0] thr_q;
  logic       valid_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      thr_q   <= 8'h5A;
      valid_q <= 1'b0;
    end else begin
      if (state_q == StRun) begin
        thr_q <= (thr_q >> 1) ^ (thr_q[0] ? 8'hB8 : 8'h00);
      end
      unique case (state_q)
        StIdle: valid_q <= start && (burst_len != 16'd0);
        StRun: begin
          if (hs && last_beat) begin
            valid_q <= 1'b0;
          end else begin
            // A pending beat is held; a free slot is filled only when the throttle allows.
            valid_q <= (valid_q & ~m_axis_tready) | thr_q[0];
          end
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign tvalid = valid_q;
`else
  assign tvalid = (state_q == StRun);
`endif

  always_comb begin
    m_axis_tdata                   = '0;
    m_axis_tdata[LFSR_WIDTH-1:0]   = lfsr_q;
    m_axis_tvalid                  = tvalid;
    m_axis_tlast                   = (state_q == StRun) && last_beat;
    busy                           = (state_q == StRun);
    done                           = (state_q == StDone);
    sent_count                     = cnt_q;
  end

endmodule

// File: tb/tb_lfsr_axis_src.sv
// Directed self-checking bench for lfsr_axis_src (default, unthrottled build).
module tb_lfsr_axis_src;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] burst_len;
  logic        seed_load;
  logic [15:0] seed_value;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  int tests = 0;
  int fails = 0;

  lfsr_axis_src dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .burst_len     (burst_len),
    .seed_load     (seed_load),
    .seed_value    (seed_value),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; burst_len = 16'd0; seed_load = 1'b0;
    seed_value = 16'd0; m_axis_tready = 1'b0;
    tick(); tick();
    areset = 1'b0;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(sent_count), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'h0000ACE1);

    // Burst of 4, tready high.
    burst_len = 16'd4; start = 1'b1; m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    check("b1_busy", 32'(busy), 32'd1);
    check("b1_d0", m_axis_tdata, 32'h0000ACE1);
    check("b1_v0", 32'(m_axis_tvalid), 32'd1);
    check("b1_l0", 32'(m_axis_tlast), 32'd0);
    tick();
    check("b1_d1", m_axis_tdata, 32'h0000E270);
    check("b1_l1", 32'(m_axis_tlast), 32'd0);
    tick();
    check("b1_d2", m_axis_tdata, 32'h00007138);
    check("b1_l2", 32'(m_axis_tlast), 32'd0);
    tick();
    check("b1_d3", m_axis_tdata, 32'h0000389C);
    check("b1_l3", 32'(m_axis_tlast), 32'd1);
    check("b1_v3", 32'(m_axis_tvalid), 32'd1);
    tick();
    check("b1_done", 32'(done), 32'd1);
    check("b1_vend", 32'(m_axis_tvalid), 32'd0);
    check("b1_lend", 32'(m_axis_tlast), 32'd0);
    check("b1_count", 32'(sent_count), 32'd4);
    check("b1_idle_tdata", m_axis_tdata, 32'h00001C4E);
    tick();
    check("b1_done_off", 32'(done), 32'd0);

    // Zero seed together with start restores SEED; stall on beat 2.
    seed_load = 1'b1; seed_value = 16'd0; start = 1'b1; burst_len = 16'd4;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("b2_d0", m_axis_tdata, 32'h0000ACE1);
    tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b2_stall_d", m_axis_tdata, 32'h0000E270);
      check("b2_stall_v", 32'(m_axis_tvalid), 32'd1);
      check("b2_stall_l", 32'(m_axis_tlast), 32'd0);
      tick();
    end
    m_axis_tready = 1'b1;
    check("b2_d1", m_axis_tdata, 32'h0000E270);
    check("b2_cnt_stall", 32'(sent_count), 32'd1);
    tick();
    check("b2_d2", m_axis_tdata, 32'h00007138);
    tick();
    check("b2_d3", m_axis_tdata, 32'h0000389C);
    check("b2_l3", 32'(m_axis_tlast), 32'd1);
    tick();
    check("b2_done", 32'(done), 32'd1);
    check("b2_count", 32'(sent_count), 32'd4);
    tick();

    // Explicit seed 0x0001, burst of 2.
    seed_load = 1'b1; seed_value = 16'h0001;
    tick();
    seed_load = 1'b0;
    check("s_idle_tdata", m_axis_tdata, 32'h00000001);
    burst_len = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("s_d0", m_axis_tdata, 32'h00000001);
    check("s_l0", 32'(m_axis_tlast), 32'd0);
    tick();
    check("s_d1", m_axis_tdata, 32'h0000B400);
    check("s_l1", 32'(m_axis_tlast), 32'd1);
    tick();
    check("s_done", 32'(done), 32'd1);
    check("s_count", 32'(sent_count), 32'd2);
    tick();

    // Zero-length burst.
    burst_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done", 32'(done), 32'd1);
    check("z_valid", 32'(m_axis_tvalid), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    tick();
    check("z_done_off", 32'(done), 32'd0);
    check("z_valid2", 32'(m_axis_tvalid), 32'd0);

    // Mid-burst start is ignored, then reset aborts the burst.
    burst_len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("m_d0", m_axis_tdata, 32'h00005A00);
    tick();
    start = 1'b1; burst_len = 16'd2;
    tick();
    start = 1'b0;
    check("m_busy", 32'(busy), 32'd1);
    check("m_count", 32'(sent_count), 32'd2);
    check("m_tlast", 32'(m_axis_tlast), 32'd0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("r_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_count", 32'(sent_count), 32'd0);
    check("r_tdata", m_axis_tdata, 32'h0000ACE1);
    tick();
    check("r_done2", 32'(done), 32'd0);
    burst_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("r_d0", m_axis_tdata, 32'h0000ACE1);
    check("r_v0", 32'(m_axis_tvalid), 32'd1);
    tick();
    check("r_d1", m_axis_tdata, 32'h0000E270);
    tick();
    check("r_d2", m_axis_tdata, 32'h00007138);
    check("r_l2", 32'(m_axis_tlast), 32'd1);
    tick();
    check("r_done3", 32'(done), 32'd1);
    check("r_count3", 32'(sent_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
